// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_slave
// Brief    : AXI4-Lite slave endpoint backing NUM_REGS word-aligned R/W
//            registers. AW and W are captured in independent 1-deep slots
//            and committed together; writes complete silently (no B
//            channel). Reads are served by a small R-channel FSM.
//            Optional build macro AXIL_REG_SLV_RD_PIPE_EN adds a wait
//            state so RVALID rises two cycles after the AR handshake.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int         c_IDX_W  = $clog2(NUM_REGS);
    localparam logic [1:0] c_R_IDLE = 2'd0;
`ifdef AXIL_REG_SLV_RD_PIPE_EN
    localparam logic [1:0] c_R_WAIT = 2'd1;
`endif
    localparam logic [1:0] c_R_DATA = 2'd2;

    logic                  r_rst_done;
    logic                  r_aw_full;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic                  r_aw_oor;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
`ifdef AXIL_REG_SLV_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] r_rd_pipe;
`endif

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_arready;
    logic                  w_rd_load;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_rd_oor;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_addr_bits;

    // Byte-lane bits of the addresses carry no meaning for word registers.
    assign w_unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    assign AWREADY  = r_rst_done & ~r_aw_full;
    assign WREADY   = r_rst_done & ~r_w_full;
    assign ARREADY  = w_arready;
    assign RVALID   = (r_state == c_R_DATA);
    assign RDATA    = r_rdata;

    assign w_aw_hs  = AWVALID & AWREADY;
    assign w_w_hs   = WVALID & WREADY;
    assign w_ar_hs  = ARVALID & w_arready;
    assign w_commit = r_aw_full & r_w_full;

    assign w_rd_idx  = ARADDR[c_IDX_W+1:2];
    assign w_rd_oor  = |ARADDR[ADDR_WIDTH-1:c_IDX_W+2];
    assign w_rd_word = w_rd_oor ? '0 : r_regs[w_rd_idx];

    // Hold READY low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    // AW/W holding slots: load on handshake, both drain on the commit edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= AWADDR[c_IDX_W+1:2];
                r_aw_oor  <= |AWADDR[ADDR_WIDTH-1:c_IDX_W+2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= WDATA;
            end
        end
    end

    // Register bank: commit a paired AW/W; out-of-range writes are dropped.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && !r_aw_oor) begin
            r_regs[r_aw_idx] <= r_w_data;
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= c_R_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Read FSM next-state and ARREADY / data-load decode.
    always_comb begin
        w_state_nxt = r_state;
        w_arready   = 1'b0;
        w_rd_load   = 1'b0;
        case (r_state)
            c_R_IDLE: begin
                w_arready = r_rst_done;
                if (ARVALID && r_rst_done) begin
`ifdef AXIL_REG_SLV_RD_PIPE_EN
                    w_state_nxt = c_R_WAIT;
`else
                    w_state_nxt = c_R_DATA;
                    w_rd_load   = 1'b1;
`endif
                end
            end
`ifdef AXIL_REG_SLV_RD_PIPE_EN
            c_R_WAIT: begin
                w_state_nxt = c_R_DATA;
                w_rd_load   = 1'b1;
            end
`endif
            c_R_DATA: begin
                if (RREADY) w_state_nxt = c_R_IDLE;
            end
            default: w_state_nxt = c_R_IDLE;
        endcase
    end

    // Read data: the word is sampled at the AR handshake edge (pre-commit
    // value on a same-edge collision) and RDATA holds until the next read.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdata   <= '0;
`ifdef AXIL_REG_SLV_RD_PIPE_EN
            r_rd_pipe <= '0;
`endif
        end else begin
`ifdef AXIL_REG_SLV_RD_PIPE_EN
            if (w_ar_hs)   r_rd_pipe <= w_rd_word;
            if (w_rd_load) r_rdata   <= r_rd_pipe;
`else
            if (w_rd_load) r_rdata   <= w_rd_word;
`endif
        end
    end

endmodule
`default_nettype wire
